// File: rtl/regfile_2r1w_if.sv
// rtl/regfile_2r1w_if.sv - read/write port bundle for the 2-read 1-write register file
interface regfile_2r1w_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] rs1_addr;
   logic [ADDR_WIDTH-1:0] rs2_addr;
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_busy;

   modport master (
      output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
      input  rs1_data, rs2_data, wr_busy
   );

   modport slave (
      input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
      output rs1_data, rs2_data, wr_busy
   );
endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read 1-write register file, x0 hardwired to zero, write-first bypass
module regfile_2r1w #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic            clk,
   input logic            rst_n,
   regfile_2r1w_if.slave  rf
);
   localparam int NREG = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NREG];
   logic                  busy_q;
   logic                  wr_accept;
   logic [DATA_WIDTH-1:0] rs1_q;
   logic [DATA_WIDTH-1:0] rs2_q;

   assign wr_accept = rf.wr_en && (rf.wr_addr != '0);

   // Entry 0 is cleared by reset and never written, so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs   <= '{default: '0};
         busy_q <= 1'b0;
      end else begin
         busy_q <= wr_accept;
         if (wr_accept) begin
            regs[rf.wr_addr] <= rf.wr_data;
         end
      end
   end

   // Reads see the in-flight write; bypass is suppressed while in reset.
   always_comb begin
      rs1_q = '0;
      if (rst_n && (rf.rs1_addr != '0)) begin
         rs1_q = (wr_accept && (rf.wr_addr == rf.rs1_addr)) ? rf.wr_data : regs[rf.rs1_addr];
      end
   end

   always_comb begin
      rs2_q = '0;
      if (rst_n && (rf.rs2_addr != '0)) begin
         rs2_q = (wr_accept && (rf.wr_addr == rf.rs2_addr)) ? rf.wr_data : regs[rf.rs2_addr];
      end
   end

   assign rf.rs1_data = rs1_q;
   assign rf.rs2_data = rs2_q;
   assign rf.wr_busy  = busy_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - self-checking bench for regfile_2r1w against an array reference model
module tb_regfile_2r1w;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 2 ** AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   regfile_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   regfile_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (bus.slave)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] model [NREG];
   logic          cur_we;
   logic [AW-1:0] cur_wa;
   logic [DW-1:0] cur_wd;
   int            compared   = 0;
   int            mismatched = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
      if (a == '0 || !rst_n) return '0;
      if (cur_we && cur_wa == a) return cur_wd;
      return model[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NREG; i++) model[i] = '0;
   endtask

   task automatic apply(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      cur_we = we; cur_wa = wa; cur_wd = wd;
      bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
      bus.rs1_addr = a1; bus.rs2_addr = a2;
   endtask

   // One full cycle: drive after negedge, check reads mid-cycle, check wr_busy after the edge.
   task automatic cycle(input string tag, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      logic exp_busy;
      @(negedge clk);
      apply(we, wa, wd, a1, a2);
      #1;
      check({tag, ".rs1"}, bus.rs1_data, expect_rd(a1));
      check({tag, ".rs2"}, bus.rs2_data, expect_rd(a2));
      exp_busy = we && (wa != '0);
      @(posedge clk);
      if (exp_busy) model[wa] = wd;
      #1;
      check({tag, ".busy"}, {{(DW-1){1'b0}}, bus.wr_busy}, {{(DW-1){1'b0}}, exp_busy});
   endtask

   initial begin
      logic          we;
      logic [AW-1:0] wa, a1, a2;
      logic [DW-1:0] wd;

      model_clear();
      apply(1'b0, '0, '0, '0, '0);
      #1;
      check("reset.busy", {{(DW-1){1'b0}}, bus.wr_busy}, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < NREG; i++) begin
         bus.rs1_addr = AW'(i);
         bus.rs2_addr = AW'(NREG - 1 - i);
         #1;
         check("rst_read.rs1", bus.rs1_data, '0);
         check("rst_read.rs2", bus.rs2_data, '0);
      end

      cycle("wr_x5", 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd1);
      cycle("rd_x5", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      check("rd_x5.const", bus.rs1_data, 32'hDEADBEEF);

      cycle("wr_x0", 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
      cycle("rd_x0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      cycle("x7_init", 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
      cycle("bypass", 1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7);
      cycle("x7_after", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
      check("x7_after.const", bus.rs2_data, 32'hA5A5A5A5);

      cycle("b2b_a", 1'b1, 5'd12, 32'h11111111, 5'd12, 5'd0);
      cycle("b2b_b", 1'b1, 5'd12, 32'h22222222, 5'd12, 5'd12);
      cycle("b2b_rd", 1'b0, 5'd0, 32'h0, 5'd12, 5'd31);

      // Reset asserted between edges while a write to x9 is pending.
      @(negedge clk);
      apply(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd5);
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      check("rst_mid.rs1", bus.rs1_data, '0);
      check("rst_mid.rs2", bus.rs2_data, '0);
      check("rst_mid.busy", {{(DW-1){1'b0}}, bus.wr_busy}, '0);
      @(posedge clk);
      #1;
      check("rst_edge.busy", {{(DW-1){1'b0}}, bus.wr_busy}, '0);
      rst_n = 1'b1;
      cycle("post_rst_wr", 1'b1, 5'd3, 32'h0BADF00D, 5'd9, 5'd7);
      cycle("post_rst_rd", 1'b0, 5'd0, 32'h0, 5'd9, 5'd3);

      for (int n = 0; n < 10000; n++) begin
         we = ($urandom_range(0, 3) != 0);
         wa = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
         wd = $urandom;
         a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
         a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
         cycle("rand", we, wa, wd, a1, a2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
